// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - configurable serial pattern detector with windowed runs
module seq_det_ctrl #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [7:0]       cfg_pattern,
  input  logic [2:0]       cfg_len,
  input  logic [WIN_W-1:0] cfg_window,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  input  logic             din,
  input  logic             din_valid,
  output logic             dout,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       pat_q, pat_d;
  logic [2:0]       len_q, len_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [7:0]       hist_q, hist_d;
  logic [WIN_W-1:0] bitcnt_q, bitcnt_d;
  logic [3:0]       seen_q, seen_d;
  logic             dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0]       hist_shift;
  logic [3:0]       seen_inc;
  logic [WIN_W-1:0] bitcnt_inc;
  logic [3:0]       pat_len;
  logic [7:0]       len_mask;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;

  // Match is judged on the history including the bit being consumed now.
  assign hist_shift = {hist_q[6:0], din};
  assign seen_inc   = (seen_q == 4'd8) ? seen_q : seen_q + 4'd1;
  assign bitcnt_inc = bitcnt_q + 1'b1;
  assign pat_len    = {1'b0, len_q} + 4'd1;
  assign len_mask   = 8'hFF >> (3'd7 - len_q);
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign hit        = (((hist_shift ^ pat_q) & len_mask) == 8'h00) && (seen_inc >= pat_len);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pat_q    <= 8'h09;
      len_q    <= 3'd3;
      win_q    <= '0;
      hist_q   <= 8'h00;
      bitcnt_q <= '0;
      seen_q   <= 4'd0;
      dout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      win_q    <= win_d;
      hist_q   <= hist_d;
      bitcnt_q <= bitcnt_d;
      seen_q   <= seen_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    win_d    = win_q;
    hist_d   = hist_q;
    bitcnt_d = bitcnt_q;
    seen_d   = seen_q;
    dout_d   = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          pat_d = cfg_pattern;
          len_d = cfg_len;
          win_d = cfg_window;
        end
        if (start) begin
          state_d  = S_RUN;
          hist_d   = 8'h00;
          bitcnt_d = '0;
          seen_d   = 4'd0;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (din_valid) begin
          hist_d   = hist_shift;
          seen_d   = seen_inc;
          bitcnt_d = bitcnt_inc;
          dout_d   = hit;
          if (hit) cnt_d = cnt_inc;
          if ((win_q != '0) && (bitcnt_inc == win_q)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_ready   = (state_q == S_IDLE);
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign dout        = dout_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - scoreboard bench for seq_det_ctrl
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid, start, stop, din, din_valid;
  logic [7:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic [7:0] cfg_window;
  logic       cfg_ready, dout, busy, done;
  logic [7:0] match_count;

  typedef struct {
    logic is_done;
    int   cnt;
    int   cyc;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;
  int  ncyc  = 0;

  seq_det_ctrl #(.CNT_W(8), .WIN_W(8)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_window(cfg_window), .cfg_ready(cfg_ready),
    .start(start), .stop(stop), .din(din), .din_valid(din_valid),
    .dout(dout), .match_count(match_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mon_pop(input logic kind);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: cyc %0d count %0d, nothing expected", kind ? "done" : "dout", ncyc, match_count);
    end else begin
      e = q.pop_front();
      if (e.is_done != kind || e.cnt != int'(match_count) || e.cyc != ncyc) begin
        bad++;
        $display("FAIL event_%s: got kind=%0d count=%0d cyc=%0d expected kind=%0d count=%0d cyc=%0d",
                 kind ? "done" : "dout", kind, match_count, ncyc, e.is_done, e.cnt, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (dout === 1'b1) mon_pop(1'b0);
    if (done === 1'b1) mon_pop(1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] p, input logic [2:0] l, input logic [7:0] w, input logic with_start);
    cfg_valid   = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_window  = w;
    start       = with_start;
    step();
    cfg_valid   = 1'b0;
    start       = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // A bit sampled at the next rising edge shows its dout/done at the negedge after that edge.
  task automatic send_bit(input logic b, input logic m, input int c, input logic d);
    ev_t e;
    din       = b;
    din_valid = 1'b1;
    if (m) begin e.is_done = 1'b0; e.cnt = c; e.cyc = ncyc + 2; q.push_back(e); end
    if (d) begin e.is_done = 1'b1; e.cnt = c; e.cyc = ncyc + 2; q.push_back(e); end
    step();
    din_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    din = 1'b0; din_valid = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 3'd0; cfg_window = 8'd0;
    #2;
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", match_count, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    step();
    reset = 1'b1;
    step();

    // default pattern 1001, overlapping stream
    start_run();
    chk("run_busy", busy, 1);
    chk("run_cfg_ready", cfg_ready, 0);
    send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(1, 1, 1, 0);
    send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(1, 1, 2, 0);
    send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(1, 1, 3, 0);
    step();
    chk("t1_dout_idle_valid_low", dout, 0);
    stop_run();
    chk("t1_count_held", match_count, 3);
    chk("t1_busy_after_stop", busy, 0);

    // pattern 11, overlap
    cfg_write(8'b11, 3'd1, 8'd0, 1'b0);
    start_run();
    send_bit(1, 0, 0, 0); send_bit(1, 1, 1, 0); send_bit(1, 1, 2, 0); send_bit(1, 1, 3, 0);
    stop_run();
    chk("t2_count", match_count, 3);

    // window of 5 with match on the last bit
    cfg_write(8'h09, 3'd3, 8'd5, 1'b0);
    start_run();
    send_bit(0, 0, 0, 0); send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0);
    send_bit(1, 1, 1, 1);
    chk("t3_done_state_busy", busy, 0);
    step();
    chk("t3_idle_cfg_ready", cfg_ready, 1);
    chk("t3_done_cleared", done, 0);
    chk("t3_count_held", match_count, 1);

    // stop coincident with a matching bit
    cfg_write(8'h09, 3'd3, 8'd0, 1'b1);
    send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0);
    din = 1'b1; din_valid = 1'b1; stop = 1'b1;
    step();
    din_valid = 1'b0; stop = 1'b0;
    chk("t4_dout", dout, 0);
    chk("t4_cfg_ready", cfg_ready, 1);
    chk("t4_count", match_count, 0);
    step();

    // config written together with start
    cfg_write(8'b101, 3'd2, 8'd0, 1'b1);
    chk("t5_busy", busy, 1);
    send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(1, 1, 1, 0); send_bit(0, 0, 0, 0);
    send_bit(1, 1, 2, 0);
    stop_run();
    chk("t5_count", match_count, 2);

    // asynchronous reset in the middle of a run
    start_run();
    send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(1, 1, 1, 0); send_bit(0, 0, 0, 0);
    chk("t6_count_before_reset", match_count, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_count", match_count, 0);
    chk("t6_rst_cfg_ready", cfg_ready, 1);
    step();
    reset = 1'b1;
    step();
    start_run();
    send_bit(1, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(0, 0, 0, 0); send_bit(1, 1, 1, 0);
    stop_run();
    chk("t6_default_cfg_count", match_count, 1);

    step(); step(); step();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
